// File: rtl/instruction_pkg.sv
// Shared instruction-level types for the execution-stage hazard logic:
// hazard FSM states, operand-forwarding selects and memory-op decode.
package instruction_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        FLUSH     = 2'd2
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_M  = 2'd1,
        FWD_W  = 2'd2
    } fwd_sel_e;

    localparam logic [3:0] MINST_NONE = 4'b1100;

    // Loads are 0fff; stores 1fff and "none" 11xx both have bit 3 set.
    function automatic logic minst_is_load(input logic [3:0] minst);
        return (minst & 4'b1000) == 4'b0000;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Combinational comparator for one source register against the M and W slots.
// Returns the operand select; the youngest-ready producer (W load data) wins.
module hazard_match
    import instruction_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic       i_m_valid,
    input  logic [4:0] i_m_rd,
    input  logic       i_w_valid,
    input  logic [4:0] i_w_rd,
    output fwd_sel_e   o_sel
);

    // NOTE: o_sel is defaulted before any branch so no path can infer a latch.
    always_comb begin
        o_sel = FWD_RF;
        if (i_rs != 5'd0) begin
            if (i_w_valid && (i_w_rd == i_rs)) begin
                o_sel = FWD_W;
            end else if (i_m_valid && (i_m_rd == i_rs)) begin
                o_sel = FWD_M;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Execution-stage hazard controller: load-use stall, operand forwarding, branch kill.
// Build option HAZARD_FWD_EN enables forwarding; without it every RAW match stalls.
module hazard_ctrl
    import instruction_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic            rdx_v,
    input  logic            rdm_v,
    input  logic [3:0]      minst,
    input  logic            pc_v_x,
    input  logic [XLEN-1:0] rd_data,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            hazard_x,
    output logic [1:0]      fwd_rs1,
    output logic [1:0]      fwd_rs2,
    output logic [XLEN-1:0] fwd_data_m,
    output logic [XLEN-1:0] fwd_data_w,
    output logic            kill_d,
    output logic            mem_err
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);

    hz_state_e         r_state;
    hz_state_e         w_state_nxt;
    logic              r_hazard_x;
    logic [4:0]        r_rd_m;
    logic              r_v_m;
    logic              r_ld_m;
    logic [XLEN-1:0]   r_data_m;
    logic [4:0]        r_rd_w;
    logic              r_v_w;
    logic [XLEN-1:0]   r_data_w;
    logic [3:0]        r_cnt;
    logic              r_wait_mem;
    logic [3:0]        r_wait_last;
    logic              r_mem_err;

    logic              w_x_load;
    logic              w_x_src_hit;
    logic              w_m_valid;
    logic              w_stall_req;
    logic              w_wait_mem_nxt;
    logic [3:0]        w_wait_last_nxt;
    logic              w_enter_wait;
    logic              w_timeout;
    logic [3:0]        w_cnt_inc;
    fwd_sel_e          w_sel1;
    fwd_sel_e          w_sel2;

    assign w_x_load    = rdm_v & minst_is_load(minst);
    assign w_x_src_hit = (rd != 5'd0) && ((rs1 == rd) || (rs2 == rd));
    assign w_cnt_inc   = r_cnt + 4'd1;

`ifdef HAZARD_FWD_EN
    assign w_m_valid       = r_v_m;
    assign w_stall_req     = w_x_load & w_x_src_hit;
    assign w_wait_mem_nxt  = 1'b1;
    assign w_wait_last_nxt = 4'd0;
    assign fwd_rs1         = r_hazard_x ? FWD_RF : w_sel1;
    assign fwd_rs2         = r_hazard_x ? FWD_RF : w_sel2;
`else
    // Without forwarding an M-slot hit means the value is not yet in the register
    // file; a W hit on the same register is the retiring producer and needs no stall.
    logic w_x_hit;
    logic w_m_hit;
    assign w_m_valid       = r_v_m | r_ld_m;
    assign w_x_hit         = (rdx_v | rdm_v) & w_x_src_hit;
    assign w_m_hit         = (w_sel1 == FWD_M) || (w_sel2 == FWD_M);
    assign w_stall_req     = w_x_hit | w_m_hit;
    assign w_wait_mem_nxt  = w_x_hit & w_x_load;
    assign w_wait_last_nxt = w_x_hit ? 4'd1 : 4'd0;
    assign fwd_rs1         = FWD_RF;
    assign fwd_rs2         = FWD_RF;
`endif

    hazard_match u_match_rs1 (
        .i_rs      (rs1),
        .i_m_valid (w_m_valid),
        .i_m_rd    (r_rd_m),
        .i_w_valid (r_v_w),
        .i_w_rd    (r_rd_w),
        .o_sel     (w_sel1)
    );

    hazard_match u_match_rs2 (
        .i_rs      (rs2),
        .i_m_valid (w_m_valid),
        .i_m_rd    (r_rd_m),
        .i_w_valid (r_v_w),
        .i_w_rd    (r_rd_w),
        .o_sel     (w_sel2)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_wait = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            RUN: begin
                if (pc_v_x) begin
                    w_state_nxt = FLUSH;
                end else if (w_stall_req) begin
                    w_state_nxt  = LOAD_WAIT;
                    w_enter_wait = 1'b1;
                end
            end
            LOAD_WAIT: begin
                if (r_wait_mem ? mem_valid : (r_cnt == r_wait_last)) begin
                    w_state_nxt = RUN;
                end else if (w_cnt_inc == TIMEOUT_CNT) begin
                    w_state_nxt = RUN;
                    w_timeout   = 1'b1;
                end
            end
            FLUSH:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_hazard_x  <= 1'b0;
            r_rd_m      <= 5'd0;
            r_v_m       <= 1'b0;
            r_ld_m      <= 1'b0;
            r_data_m    <= '0;
            r_rd_w      <= 5'd0;
            r_v_w       <= 1'b0;
            r_data_w    <= '0;
            r_cnt       <= 4'd0;
            r_wait_mem  <= 1'b0;
            r_wait_last <= 4'd0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hazard_x <= (w_state_nxt == LOAD_WAIT);

            if (w_enter_wait) begin
                r_cnt       <= 4'd0;
                r_wait_mem  <= w_wait_mem_nxt;
                r_wait_last <= w_wait_last_nxt;
            end else if (r_state == LOAD_WAIT) begin
                r_cnt <= w_cnt_inc;
            end

            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end

            // The M slot holds its producer while X is stalled.
            if (!r_hazard_x) begin
                r_rd_m   <= rd;
                r_v_m    <= rdx_v;
                r_ld_m   <= w_x_load;
                r_data_m <= rd_data;
            end

            r_v_w <= mem_valid;
            if (mem_valid) begin
                r_rd_w   <= r_rd_m;
                r_data_w <= mem_rdata;
            end
        end
    end

    assign hazard_x   = r_hazard_x;
    assign kill_d     = pc_v_x | (r_state == FLUSH);
    assign fwd_data_m = r_data_m;
    assign fwd_data_w = r_data_w;
    assign mem_err    = r_mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle queues its expected outputs,
// a negedge monitor pops and compares. Expectations follow the HAZARD_FWD_EN build.
module tb_hazard_ctrl;
    import instruction_pkg::*;

    localparam int XLEN = 32;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      rs1, rs2, rd;
    logic            rdx_v, rdm_v;
    logic [3:0]      minst;
    logic            pc_v_x;
    logic [XLEN-1:0] rd_data;
    logic            mem_valid;
    logic [XLEN-1:0] mem_rdata;
    logic            hazard_x;
    logic [1:0]      fwd_rs1, fwd_rs2;
    logic [XLEN-1:0] fwd_data_m, fwd_data_w;
    logic            kill_d;
    logic            mem_err;

    always #5 clk = ~clk;

    hazard_ctrl #(.XLEN(XLEN), .MEM_TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .rdx_v      (rdx_v),
        .rdm_v      (rdm_v),
        .minst      (minst),
        .pc_v_x     (pc_v_x),
        .rd_data    (rd_data),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
        .hazard_x   (hazard_x),
        .fwd_rs1    (fwd_rs1),
        .fwd_rs2    (fwd_rs2),
        .fwd_data_m (fwd_data_m),
        .fwd_data_w (fwd_data_w),
        .kill_d     (kill_d),
        .mem_err    (mem_err)
    );

    typedef struct {
        int          id;
        logic        hz;
        logic        kill;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        err;
        logic        c_dm;
        logic [31:0] dm;
        logic        c_dw;
        logic [31:0] dw;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          vec_id = 0;
    logic        want_dm_c = 1'b0;
    logic        want_dw_c = 1'b0;
    logic [31:0] want_dm = '0;
    logic [31:0] want_dw = '0;

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    task automatic idle();
        reset     = 1'b0;
        rs1       = 5'd0;
        rs2       = 5'd0;
        rd        = 5'd0;
        rdx_v     = 1'b0;
        rdm_v     = 1'b0;
        minst     = MINST_NONE;
        pc_v_x    = 1'b0;
        rd_data   = '0;
        mem_valid = 1'b0;
        mem_rdata = '0;
    endtask

    // Queue what this cycle's outputs must be, then advance to the next cycle.
    task automatic tick(input logic hz, input logic kill, input logic [1:0] f1,
                        input logic [1:0] f2, input logic err);
        exp_t e;
        e.id   = vec_id;
        e.hz   = hz;
        e.kill = kill;
        e.f1   = f1;
        e.f2   = f2;
        e.err  = err;
        e.c_dm = want_dm_c;
        e.dm   = want_dm;
        e.c_dw = want_dw_c;
        e.dw   = want_dw;
        q.push_back(e);
        want_dm_c = 1'b0;
        want_dw_c = 1'b0;
        vec_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_dm(input logic [31:0] v);
        want_dm_c = 1'b1;
        want_dm   = v;
    endtask

    task automatic exp_dw(input logic [31:0] v);
        want_dw_c = 1'b1;
        want_dw   = v;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("hazard_x", e.id, 32'(hazard_x), 32'(e.hz));
                check("kill_d",   e.id, 32'(kill_d),   32'(e.kill));
                check("fwd_rs1",  e.id, 32'(fwd_rs1),  32'(e.f1));
                check("fwd_rs2",  e.id, 32'(fwd_rs2),  32'(e.f2));
                check("mem_err",  e.id, 32'(mem_err),  32'(e.err));
                if (e.c_dm) check("fwd_data_m", e.id, fwd_data_m, e.dm);
                if (e.c_dw) check("fwd_data_w", e.id, fwd_data_w, e.dw);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        idle(); exp_dm(32'h0); exp_dw(32'h0); tick(0, 0, 0, 0, 0);

        // Load x5 in X with add x6,x5,x1 in decode; data returns in the first stall cycle.
        idle(); rs1 = 5'd5; rs2 = 5'd1; rd = 5'd5; rdm_v = 1'b1; minst = 4'b0010;
        rd_data = 32'h100;
        tick(0, 0, 0, 0, 0);
        idle(); rs1 = 5'd5; rs2 = 5'd1; rd = 5'd6; rdx_v = 1'b1;
        mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF; exp_dm(32'h100);
        tick(1, 0, 0, 0, 0);
        idle(); rs1 = 5'd5; rs2 = 5'd1; rd = 5'd6; rdx_v = 1'b1; rd_data = 32'h77;
        exp_dw(32'hDEADBEEF);
        tick(0, 0, FWD ? 2'd2 : 2'd0, 0, 0);
        idle(); exp_dm(32'h77); tick(0, 0, 0, 0, 0);

        // addi x7,x0,3 then sub x8,x7,x7: forwarded from M, or two stall cycles.
        idle(); rs1 = 5'd7; rs2 = 5'd7; rd = 5'd7; rdx_v = 1'b1; rd_data = 32'd3;
        tick(0, 0, 0, 0, 0);
        idle(); rs1 = 5'd7; rs2 = 5'd7; rd = 5'd8; rdx_v = 1'b1; rd_data = 32'h10;
        exp_dm(32'd3);
        tick(!FWD, 0, FWD ? 2'd1 : 2'd0, FWD ? 2'd1 : 2'd0, 0);
        idle(); rs1 = 5'd7; rs2 = 5'd7; rd = 5'd8; rdx_v = 1'b1; rd_data = 32'h10;
        exp_dm(FWD ? 32'h10 : 32'd3);
        tick(!FWD, 0, 0, 0, 0);
        idle(); tick(0, 0, 0, 0, 0);

        // Taken branch coinciding with a load-use match: branch wins, kill for 2 cycles.
        idle(); rs1 = 5'd9; rd = 5'd9; rdm_v = 1'b1; minst = 4'b0000; rd_data = 32'h200;
        pc_v_x = 1'b1;
        tick(0, 1, 0, 0, 0);
        idle(); tick(0, 1, 0, 0, 0);
        idle(); tick(0, 0, 0, 0, 0);

        // Load whose data never returns: 15 stall cycles, then mem_err as stall drops.
        idle(); rs2 = 5'd10; rd = 5'd10; rdm_v = 1'b1; minst = 4'b0001; rd_data = 32'h300;
        tick(0, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            idle(); tick(1, 0, 0, 0, 0);
        end
        idle(); tick(0, 0, 0, 0, 1);
        idle(); tick(0, 0, 0, 0, 1);

        // Reset during the second stall cycle of a load-use wait.
        idle(); rs1 = 5'd11; rd = 5'd11; rdm_v = 1'b1; minst = 4'b0000; rd_data = 32'h400;
        tick(0, 0, 0, 0, 1);
        idle(); tick(1, 0, 0, 0, 1);
        idle(); reset = 1'b1; tick(1, 0, 0, 0, 1);
        idle(); rs1 = 5'd11; rs2 = 5'd11; exp_dm(32'h0); exp_dw(32'h0);
        tick(0, 0, 0, 0, 0);
        idle(); tick(0, 0, 0, 0, 0);

        // Dependence on x0: never stalls and never forwards, even with valid x0 slots.
        idle(); rd = 5'd0; rdm_v = 1'b1; minst = 4'b0000;
        tick(0, 0, 0, 0, 0);
        idle(); rd = 5'd0; rdx_v = 1'b1; mem_valid = 1'b1; mem_rdata = 32'hABCD;
        tick(0, 0, 0, 0, 0);
        idle(); exp_dw(32'hABCD); tick(0, 0, 0, 0, 0);

        // Memory return together with a taken branch: W still captures, FSM flushes.
        idle(); pc_v_x = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h1234;
        tick(0, 1, 0, 0, 0);
        idle(); exp_dw(32'h1234); tick(0, 1, 0, 0, 0);
        idle(); tick(0, 0, 0, 0, 0);

        // Same register valid in both M and W: W load data has priority.
        idle(); rd = 5'd13; rdx_v = 1'b1; rd_data = 32'h42;
        tick(0, 0, 0, 0, 0);
        idle(); rd = 5'd13; rdx_v = 1'b1; rd_data = 32'h43;
        mem_valid = 1'b1; mem_rdata = 32'h99; exp_dm(32'h42);
        tick(0, 0, 0, 0, 0);
        idle(); rs1 = 5'd13; rs2 = 5'd13; exp_dm(32'h43); exp_dw(32'h99);
        tick(0, 0, FWD ? 2'd2 : 2'd0, FWD ? 2'd2 : 2'd0, 0);
        idle(); tick(0, 0, 0, 0, 0);

        for (int n = 0; n < 4 && q.size() > 0; n++) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
